// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one sram-style memory port between instruction fetch
// and MEM-stage data access. Data has priority, a starvation counter lets a
// waiting fetch through, and a wait counter aborts transactions that get no
// mem_ready within TIMEOUT grant cycles.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  // data access side
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  // shared memory port
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  // abort indication
  output logic        bus_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t               state;
  logic [STARVE_W-1:0]  starveCnt;
  logic [WAIT_W-1:0]    waitCnt;

  logic instView;
  logic dataView;
  logic pickData;
  logic pickInst;
  logic timeoutHit;
  logic xferWrite;

  // Arbitration view: a requester still holding req during its own ok cycle
  // is finishing, not asking again, so it is masked for that cycle.
  always_comb begin
    instView   = inst_req & ~inst_ok;
    dataView   = data_req & ~data_ok;
    pickData   = dataView & (~instView | (starveCnt < STARVE_MAX));
    pickInst   = instView & ~pickData;
    timeoutHit = (waitCnt == WAIT_LAST);
    xferWrite  = |mem_wen;
  end

  // Arbiter FSM with registered memory-port and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starveCnt  <= '0;
      waitCnt    <= '0;
      mem_req    <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ok    <= 1'b0;
      inst_rdata <= '0;
      data_ok    <= 1'b0;
      data_rdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pickData) begin
            state     <= GNT_D;
            mem_req   <= 1'b1;
            mem_wen   <= data_wen;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            waitCnt   <= '0;
            if (instView) begin
              if (starveCnt != STARVE_MAX)
                starveCnt <= starveCnt + 1'b1;
            end else begin
              starveCnt <= '0;
            end
          end else if (pickInst) begin
            state     <= GNT_I;
            mem_req   <= 1'b1;
            mem_wen   <= '0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
            waitCnt   <= '0;
            starveCnt <= '0;
          end else begin
            // nobody granted implies fetch is not waiting
            starveCnt <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == GNT_D) begin
              data_ok    <= 1'b1;
              data_rdata <= xferWrite ? '0 : mem_rdata;
            end else begin
              inst_ok    <= 1'b1;
              inst_rdata <= xferWrite ? '0 : mem_rdata;
            end
          end else if (timeoutHit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (state == GNT_D) begin
              data_ok    <= 1'b1;
              data_rdata <= '0;
            end else begin
              inst_ok    <= 1'b1;
              inst_rdata <= '0;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ok    (inst_ok),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ok    (data_ok),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err)
  );

  typedef struct packed {
    logic        memReq;
    logic [3:0]  memWen;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        instOk;
    logic [31:0] instRdata;
    logic        dataOk;
    logic [31:0] dataRdata;
    logic        busErr;
  } outs_t;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        mr;
    logic [31:0] md;
    outs_t       exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic outs_t mkOut(input logic mrq, input logic [3:0] mw, input logic [31:0] ma,
                                  input logic [31:0] mwd, input logic iok, input logic [31:0] ird,
                                  input logic dok, input logic [31:0] drd, input logic err);
    outs_t o;
    o.memReq = mrq; o.memWen = mw; o.memAddr = ma; o.memWdata = mwd;
    o.instOk = iok; o.instRdata = ird; o.dataOk = dok; o.dataRdata = drd; o.busErr = err;
    return o;
  endfunction

  function automatic vec_t mkVec(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                                 input logic mr, input logic [31:0] md, input outs_t e);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.mr = mr; v.md = md; v.exp = e;
    return v;
  endfunction

  function automatic outs_t dutOuts();
    return mkOut(mem_req, mem_wen, mem_addr, mem_wdata, inst_ok, inst_rdata,
                 data_ok, data_rdata, bus_err);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: tracks who owns the port, the captured transaction and how
  // long it has waited; predicts the outputs visible after the next clock edge.
  // ---------------------------------------------------------------------------
  outs_t       mExp;
  int          mOwner;   // 0 none, 1 fetch, 2 data
  int unsigned mAge;     // grant cycles without a memory response so far
  int unsigned mStarve;  // data wins while fetch was waiting

  task automatic modelReset();
    mExp    = '0;
    mOwner  = 0;
    mAge    = 0;
    mStarve = 0;
  endtask

  task automatic modelStep(input logic ir, input logic [31:0] ia, input logic dr,
                           input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                           input logic mr, input logic [31:0] md);
    outs_t n;
    bit iWants, dWants, finish, err;
    logic [31:0] val;
    n = mExp;
    n.instOk = 1'b0; n.dataOk = 1'b0; n.busErr = 1'b0;
    finish = 0; err = 0; val = '0;
    if (mOwner == 0) begin
      iWants = ir && !mExp.instOk;
      dWants = dr && !mExp.dataOk;
      if (dWants && (!iWants || mStarve < STARVE_LIMIT)) begin
        mOwner = 2; mAge = 0;
        n.memReq = 1'b1; n.memWen = dw; n.memAddr = da; n.memWdata = dd;
        mStarve = iWants ? ((mStarve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mStarve + 1) : 0;
      end else if (iWants) begin
        mOwner = 1; mAge = 0; mStarve = 0;
        n.memReq = 1'b1; n.memWen = 4'h0; n.memAddr = ia; n.memWdata = '0;
      end else begin
        mStarve = 0;
      end
    end else if (mr) begin
      finish = 1; val = (n.memWen == 4'h0) ? md : 32'h0;
    end else if (mAge + 1 >= TIMEOUT) begin
      finish = 1; err = 1; val = '0;
    end else begin
      mAge++;
    end
    if (finish) begin
      if (mOwner == 2) begin n.dataOk = 1'b1; n.dataRdata = val; end
      else begin n.instOk = 1'b1; n.instRdata = val; end
      n.busErr = err;
      n.memReq = 1'b0;
      mOwner = 0;
    end
    mExp = n;
  endtask

  // One complete transfer from a quiet IDLE negedge; memory answers `lat`
  // grant cycles late. Optionally scrambles requester inputs after the grant.
  task automatic xfer(input string name, input bit isData, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                      input int unsigned lat, input bit scramble);
    int unsigned gnt = 0;
    int unsigned cycles = 0;
    bit got = 0;
    bit holdOk = 1;
    logic [31:0] rd = '0;
    logic err = 1'b0;
    logic [3:0]  expWen = isData ? wen : 4'h0;
    logic [31:0] expWd  = isData ? wdata : 32'h0;
    if (isData) begin
      data_req = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    mem_ready = 1'b0;
    while (!got && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (isData ? data_ok : inst_ok) begin
        got = 1;
        rd  = isData ? data_rdata : inst_rdata;
        err = bus_err;
      end else if (mem_req) begin
        gnt++;
        if (mem_addr !== addr || mem_wen !== expWen || mem_wdata !== expWd) holdOk = 0;
        if (scramble) begin
          data_addr = $urandom; data_wdata = $urandom; data_wen = 4'($urandom);
          inst_addr = $urandom;
        end
        mem_ready = (gnt > lat);
        mem_rdata = mem_ready ? rdata : $urandom;
      end else begin
        mem_ready = 1'b0;
      end
    end
    inst_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
    chk({name, " done"}, 136'(got), 136'(1));
    chk({name, " latency"}, 136'(cycles), 136'(lat + 2));
    chk({name, " grantCycles"}, 136'(gnt), 136'(lat + 1));
    chk({name, " rdata"}, 136'(rd), 136'((|expWen) ? 32'h0 : rdata));
    chk({name, " busErr"}, 136'(err), 136'(0));
    chk({name, " latchedPort"}, 136'(holdOk), 136'(1));
    @(negedge clk);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] grants[$];
    logic [31:0] expGrant[6];
    int unsigned cnt;
    int both;
    bit got, seen;
    logic [31:0] drd;
    logic err, iok;
    bit iPend, dPend;
    int unsigned lat;
    logic ir, dr, mr;
    logic [31:0] ia, da, dd, md;
    logic [3:0] dw;

    vecs[0]  = mkVec(1, 32'hBFC00000, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
                     mkOut(0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
    vecs[1]  = mkVec(1, 32'hBFC00000, 0, 4'h0, 32'h0, 32'h0, 1, 32'h3C080001,
                     mkOut(1, 4'h0, 32'hBFC00000, 32'h0, 0, 32'h0, 0, 32'h0, 0));
    vecs[2]  = mkVec(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
                     mkOut(0, 4'h0, 32'hBFC00000, 32'h0, 1, 32'h3C080001, 0, 32'h0, 0));
    vecs[3]  = mkVec(1, 32'hBFC00004, 1, 4'hF, 32'h80000010, 32'hDEADBEEF, 0, 32'h0,
                     mkOut(0, 4'h0, 32'hBFC00000, 32'h0, 0, 32'h3C080001, 0, 32'h0, 0));
    vecs[4]  = mkVec(1, 32'hBFC00004, 1, 4'hF, 32'h80000010, 32'hDEADBEEF, 1, 32'h12345678,
                     mkOut(1, 4'hF, 32'h80000010, 32'hDEADBEEF, 0, 32'h3C080001, 0, 32'h0, 0));
    vecs[5]  = mkVec(1, 32'hBFC00004, 1, 4'hF, 32'h80000010, 32'hDEADBEEF, 0, 32'h0,
                     mkOut(0, 4'hF, 32'h80000010, 32'hDEADBEEF, 0, 32'h3C080001, 1, 32'h0, 0));
    vecs[6]  = mkVec(1, 32'hBFC00004, 0, 4'h0, 32'h0, 32'h0, 1, 32'hAABBCCDD,
                     mkOut(1, 4'h0, 32'hBFC00004, 32'h0, 0, 32'h3C080001, 0, 32'h0, 0));
    vecs[7]  = mkVec(1, 32'hBFC00004, 0, 4'h0, 32'h0, 32'h0, 1, 32'h55555555,
                     mkOut(0, 4'h0, 32'hBFC00004, 32'h0, 1, 32'hAABBCCDD, 0, 32'h0, 0));
    vecs[8]  = mkVec(0, 32'h0, 1, 4'h0, 32'h80000020, 32'h11111111, 0, 32'h0,
                     mkOut(0, 4'h0, 32'hBFC00004, 32'h0, 0, 32'hAABBCCDD, 0, 32'h0, 0));
    vecs[9]  = mkVec(0, 32'h0, 1, 4'h0, 32'h80000020, 32'h11111111, 1, 32'hCAFEF00D,
                     mkOut(1, 4'h0, 32'h80000020, 32'h11111111, 0, 32'hAABBCCDD, 0, 32'h0, 0));
    vecs[10] = mkVec(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
                     mkOut(0, 4'h0, 32'h80000020, 32'h11111111, 0, 32'hAABBCCDD, 1, 32'hCAFEF00D, 0));
    vecs[11] = mkVec(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
                     mkOut(0, 4'h0, 32'h80000020, 32'h11111111, 0, 32'hAABBCCDD, 0, 32'hCAFEF00D, 0));

    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed vector table, one row per cycle from reset
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("vec%0d", k), 136'(dutOuts()), 136'(vecs[k].exp));
      inst_req = vecs[k].ir; inst_addr = vecs[k].ia;
      data_req = vecs[k].dr; data_wen = vecs[k].dw; data_addr = vecs[k].da; data_wdata = vecs[k].dd;
      mem_ready = vecs[k].mr; mem_rdata = vecs[k].md;
      @(negedge clk);
    end

    // both requesters held continuously: data first, then strict alternation
    inst_req = 1'b1; inst_addr = 32'h00001000;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h00002000; data_wdata = 32'hAAAA5555;
    mem_ready = 1'b0;
    both = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req) grants.push_back(mem_addr);
      if (inst_ok && data_ok) both++;
      mem_ready = mem_req;
      mem_rdata = $urandom;
    end
    inst_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    expGrant = '{32'h2000, 32'h1000, 32'h2000, 32'h1000, 32'h2000, 32'h1000};
    chk("alternate count", 136'(grants.size()), 136'(6));
    for (int g = 0; g < 6 && g < grants.size(); g++)
      chk($sformatf("alternate grant%0d", g), 136'(grants[g]), 136'(expGrant[g]));
    chk("okExclusive", 136'(both), 136'(0));

    // late memory response while requester inputs keep changing
    xfer("lateWrite", 1, 4'hF, 32'h80000040, 32'h01234567, 32'hFFFFFFFF, 3, 1);
    xfer("lateFetch", 0, 4'h0, 32'hBFC00100, 32'h0, 32'h24020005, 3, 1);

    // timeout abort on a data read
    xfer("prime", 1, 4'h0, 32'h80000080, 32'h0, 32'h0BADCAFE, 0, 0);
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00003000; mem_ready = 1'b0;
    cnt = 0; got = 0; drd = '1; err = 1'b0; iok = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (data_ok) begin got = 1; drd = data_rdata; err = bus_err; iok = inst_ok; end
      else if (mem_req) cnt++;
    end
    data_req = 1'b0;
    chk("timeout done", 136'(got), 136'(1));
    chk("timeout grantCycles", 136'(cnt), 136'(TIMEOUT));
    chk("timeout busErr", 136'(err), 136'(1));
    chk("timeout rdata", 136'(drd), 136'(0));
    chk("timeout instOk", 136'(iok), 136'(0));
    @(negedge clk);
    chk("timeout errPulse", 136'({bus_err, data_ok}), 136'(0));
    xfer("afterTimeout", 0, 4'h0, 32'hBFC00200, 32'h0, 32'h8C220000, 0, 0);

    // mem_ready arriving in the last allowed cycle beats the timeout
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00003004; mem_ready = 1'b0;
    cnt = 0; got = 0; drd = '0; err = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (data_ok) begin got = 1; drd = data_rdata; err = bus_err; end
      else if (mem_req) begin
        cnt++;
        mem_ready = (cnt == TIMEOUT);
        mem_rdata = 32'h600DF00D;
      end
    end
    data_req = 1'b0; mem_ready = 1'b0;
    chk("lastCycle done", 136'(got), 136'(1));
    chk("lastCycle grantCycles", 136'(cnt), 136'(TIMEOUT));
    chk("lastCycle busErr", 136'(err), 136'(0));
    chk("lastCycle rdata", 136'(drd), 136'(32'h600DF00D));
    @(negedge clk);

    // reset in the middle of a data grant
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00004000; mem_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    chk("rst granted", 136'(got), 136'(1));
    mem_ready = 1'b1; mem_rdata = 32'h77777777;
    #2 rst = 1'b1;
    #1 chk("rst dropsReq", 136'(mem_req), 136'(0));
    data_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | inst_ok | data_ok | mem_req;
    end
    chk("rst noOk", 136'(seen), 136'(0));
    xfer("postReset", 0, 4'h0, 32'hBFC00000, 32'h0, 32'h3C080001, 0, 0);

    // randomized traffic against the reference model
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    iPend = 0; dPend = 0; lat = 0;
    for (int cyc = 0; cyc < 6000 && bad < 40; cyc++) begin
      @(negedge clk);
      chk($sformatf("rand cycle%0d", cyc), 136'(dutOuts()), 136'(mExp));
      if (inst_ok) iPend = 0;
      if (data_ok) dPend = 0;
      if (iPend && mOwner != 1 && $urandom_range(0, 15) == 0) iPend = 0;
      if (dPend && mOwner != 2 && $urandom_range(0, 15) == 0) dPend = 0;
      if (!iPend && $urandom_range(0, 2) == 0) iPend = 1;
      if (!dPend && $urandom_range(0, 2) == 0) dPend = 1;
      ir = iPend; ia = $urandom;
      dr = dPend; da = $urandom; dd = $urandom;
      dw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (mOwner != 0) begin
        if (mAge == 0) begin
          case ($urandom_range(0, 19))
            0:       lat = 300;
            1:       lat = TIMEOUT - 1;
            default: lat = $urandom_range(0, 3);
          endcase
        end
        mr = (mAge >= lat);
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      md = $urandom;
      inst_req = ir; inst_addr = ia;
      data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
      mem_ready = mr; mem_rdata = md;
      modelStep(ir, ia, dr, dw, da, dd, mr, md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
